// File: rtl/bcd_multidigit_adder.sv
// Sequential packed-BCD adder: one digit per clock, least-significant digit first,
// with valid/ready handshakes on the operand and result sides.
module bcd_multidigit_adder #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic                  sum_valid,
  input  logic                  sum_ready,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  err
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_DONE
  } state_t;

  state_t           r_state;
  logic             r_in_ready;
  logic             r_sum_valid;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_sum;
  logic             r_carry;
  logic             r_cout;
  logic             r_err;
  logic [IDX_W-1:0] r_idx;

  logic [3:0]       w_a_dig;
  logic [3:0]       w_b_dig;
  logic             w_in_err;
  logic [4:0]       w_t;
  logic [3:0]       w_s_adj;
  logic             w_gt9;
  logic [3:0]       w_s;
  logic [W-1:0]     w_sum_next;
  logic             w_last;

  // Select the active digit from the captured operands and flag any non-BCD
  // input digit on the live operand bus (only sampled at acceptance).
  // NOTE: every signal gets a default before the loop so no latch is inferred.
  always_comb begin
    w_a_dig  = 4'd0;
    w_b_dig  = 4'd0;
    w_in_err = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (IDX_W'(i) == r_idx) begin
        w_a_dig = r_a[4*i +: 4];
        w_b_dig = r_b[4*i +: 4];
      end
      if ((a[4*i +: 4] > 4'd9) || (b[4*i +: 4] > 4'd9)) begin
        w_in_err = 1'b1;
      end
    end
  end

  // Decimal correction: adding 6 modulo 16 skips the six unused nibble codes.
  assign w_t     = {1'b0, w_a_dig} + {1'b0, w_b_dig} + {4'd0, r_carry};
  assign w_s_adj = w_t[3:0] + 4'd6;
  assign w_gt9   = (w_t > 5'd9);
  assign w_s     = w_gt9 ? w_s_adj : w_t[3:0];
  assign w_last  = (r_idx == IDX_W'(DIGITS - 1));

  always_comb begin
    w_sum_next = r_sum;
    for (int i = 0; i < DIGITS; i++) begin
      if (IDX_W'(i) == r_idx) begin
        w_sum_next[4*i +: 4] = w_s;
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_sum_valid <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_cout      <= 1'b0;
      r_err       <= 1'b0;
      r_idx       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_a        <= a;
            r_b        <= b;
            r_carry    <= cin;
            r_idx      <= '0;
            r_err      <= w_in_err;
            r_sum      <= '0;
            r_cout     <= 1'b0;
            r_in_ready <= 1'b0;
            r_state    <= S_ADD;
          end
        end
        S_ADD: begin
          r_sum   <= w_sum_next;
          r_carry <= w_gt9;
          if (w_last) begin
            r_cout      <= w_gt9;
            r_sum_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        S_DONE: begin
          // Result stays parked until the consumer takes it.
          if (sum_ready) begin
            r_sum_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign sum_valid = r_sum_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign err       = r_err;

endmodule

// File: tb/tb_bcd_multidigit_adder.sv
// Self-checking bench for bcd_multidigit_adder: directed corner cases plus random
// operands compared against a decimal-arithmetic reference model.
module tb_bcd_multidigit_adder;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
  localparam int BUDGET = 50;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cin;
  logic          sum_valid;
  logic          sum_ready;
  logic [W-1:0]  sum;
  logic          cout;
  logic          err;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_multidigit_adder #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sum_valid (sum_valid),
    .sum_ready (sum_ready),
    .sum       (sum),
    .cout      (cout),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Valid BCD operands use plain decimal arithmetic; operands with non-BCD
  // nibbles fall back to the digit-serial add/correct rule.
  function automatic void ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                    input logic rc, output logic [W-1:0] rs,
                                    output logic rco, output logic re);
    longint va, vb, tot, lim;
    int     t, c;
    re = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (ra[4*i +: 4] > 4'd9 || rb[4*i +: 4] > 4'd9) re = 1'b1;
    rs = '0;
    if (!re) begin
      va = 0; vb = 0; lim = 1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
        va  = va * 10 + longint'(ra[4*i +: 4]);
        vb  = vb * 10 + longint'(rb[4*i +: 4]);
        lim = lim * 10;
      end
      tot = va + vb + longint'(rc);
      rco = (tot >= lim);
      tot = tot % lim;
      for (int i = 0; i < DIGITS; i++) begin
        rs[4*i +: 4] = 4'(tot % 10);
        tot = tot / 10;
      end
    end else begin
      c = int'(rc);
      for (int i = 0; i < DIGITS; i++) begin
        t = int'(ra[4*i +: 4]) + int'(rb[4*i +: 4]) + c;
        if (t > 9) begin
          rs[4*i +: 4] = 4'((t + 6) % 16);
          c = 1;
        end else begin
          rs[4*i +: 4] = 4'(t);
          c = 0;
        end
      end
      rco = c[0];
    end
  endfunction

  // One complete transaction: accept, latency, result, optional hold in DONE,
  // optional in_valid noise during ADD, handoff.
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic tc, input int hold, input bit noise);
    logic [W-1:0] es;
    logic         eco, ee;
    int           cyc;
    ref_model(ta, tb_, tc, es, eco, ee);
    @(negedge clk);
    check({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a = ta; b = tb_; cin = tc;
    @(posedge clk);
    #1;
    in_valid = noise;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    cyc = 0;
    while (!sum_valid && cyc < BUDGET) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) check({tag, "_in_ready_add"}, 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, 32'(cyc), 32'(DIGITS));
    check({tag, "_sum"}, 32'(sum), 32'(es));
    check({tag, "_cout"}, 32'(cout), 32'(eco));
    check({tag, "_err"}, 32'(err), 32'(ee));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold"}, {in_ready, sum_valid, cout, 13'd0, sum}, {1'b0, 1'b1, eco, 13'd0, es});
    end
    sum_ready = 1'b1;
    @(posedge clk);
    #1;
    sum_ready = 1'b0;
    check({tag, "_handoff"}, {30'd0, sum_valid, in_ready}, 32'b01);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int           seen;
    rst_n = 1'b0; in_valid = 1'b0; sum_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_state", {27'd0, in_ready, sum_valid, cout, err, 1'b0}, {27'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    check("reset_sum", 32'(sum), 32'd0);

    run_op("zero",   16'h0000, 16'h0000, 1'b0, 0, 1'b0);
    run_op("t1234",  16'h1234, 16'h5678, 1'b0, 0, 1'b0);
    run_op("t9999",  16'h9999, 16'h0001, 1'b0, 0, 1'b0);
    run_op("ripple", 16'h0999, 16'h0000, 1'b1, 0, 1'b0);
    run_op("bad",    16'h00A0, 16'h0000, 1'b0, 0, 1'b0);
    run_op("badAA",  16'h000A, 16'h000A, 1'b0, 0, 1'b0);
    run_op("allmax", 16'h9999, 16'h9999, 1'b1, 0, 1'b0);
    run_op("hold",   16'h4321, 16'h8765, 1'b1, 10, 1'b1);

    // Reset in the middle of an ADD: nothing may come out.
    @(negedge clk);
    in_valid = 1'b1; a = 16'h1234; b = 16'h5678; cin = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset_outs", {29'd0, sum_valid, cout, err}, 32'd0);
    check("midreset_sum", 32'(sum), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (sum_valid) seen++;
    end
    check("midreset_no_result", 32'(seen), 32'd0);
    run_op("after_reset", 16'h1234, 16'h5678, 1'b0, 0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      ra = '0; rb = '0;
      for (int i = 0; i < DIGITS; i++) begin
        if (n % 6 == 5) begin
          ra[4*i +: 4] = 4'($urandom_range(15, 0));
          rb[4*i +: 4] = 4'($urandom_range(15, 0));
        end else begin
          ra[4*i +: 4] = 4'($urandom_range(9, 0));
          rb[4*i +: 4] = 4'($urandom_range(9, 0));
        end
      end
      run_op("rand", ra, rb, 1'($urandom), n % 3, 1'(n % 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
